classifier_sequencer: RTL and testbench
=======================================

# classifier_sequencer

Sequencer and arg-max stage directly downstream of the `multiplier` row engine. On `start` it issues one row computation per output class (rows 0..NUM_ROWS-1), captures each signed 32-bit row result, and tracks the running maximum. When every row is done it reports the winning class index, its value and sticky overflow/timeout status. It drives the multiplier's `row_select`/`begin_mult` and consumes its `row_result`/`overflow`/`done_row`.

## Interface
- NUM_ROWS, 10, rows per classification; legal range 1..16.
- TIMEOUT, 1023, max cycles in WAIT before abort; must exceed the multiplier row latency.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  level; sampled in IDLE only.
- row_result  in  32  signed row sum from multiplier; valid while done_row=1.
- overflow  in  1  row sum overflowed 32 bits; valid while done_row=1.
- done_row  in  1  one-cycle pulse: row finished.
- row_select  out  4  row index to multiplier.
- begin_mult  out  1  one-cycle row start pulse.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  one-cycle pulse: digit/max_value final.
- digit  out  4  index of maximum row.
- max_value  out  32  signed value of maximum row (after saturation).
- ovf_seen  out  1  sticky: any row overflowed this run.
- timeout_err  out  1  sticky: run aborted on timeout.

## Operation
- States: IDLE, ISSUE, WAIT, COMPARE, DONE.
- IDLE: start=1 -> ISSUE; clear row counter, max_value, digit, ovf_seen, timeout_err; start resets the watchdog.
- ISSUE: begin_mult=1 for exactly this cycle -> WAIT; watchdog cleared.
- WAIT: watchdog increments each cycle. On done_row=1: capture saturated sample, ovf_seen |= overflow -> COMPARE. Watchdog reaching TIMEOUT without done_row: timeout_err=1 -> IDLE without result_valid; digit/max_value hold partial values.
- Saturation: overflow=1 and row_result[31]=1 (positive wrap) -> 32'h7FFF_FFFF; overflow=1 and row_result[31]=0 (negative wrap) -> 32'h8000_0000; else row_result unchanged.
- COMPARE: if row==0 or sample > max_value (signed, strict) then max_value<=sample, digit<=row. If row==NUM_ROWS-1 -> DONE, else row+=1 -> ISSUE.
- DONE: result_valid=1 for one cycle -> IDLE. digit, max_value, ovf_seen, timeout_err hold until the next accepted start.
- row_select equals the row counter and is stable from ISSUE through COMPARE of that row; returns to 0 in IDLE.
- Ties: lowest index wins (strict compare).
- start while busy: ignored. done_row outside WAIT: ignored. done_row in the same cycle the watchdog hits TIMEOUT: done_row wins, capture proceeds.

## Timing
- Reset values: row_select=0, begin_mult=0, busy=0, result_valid=0, digit=0, max_value=0, ovf_seen=0, timeout_err=0; state IDLE, watchdog 0.
- All outputs registered or decoded from registered state; no combinational input-to-output path.
- Let W = cycles from the begin_mult cycle to the done_row cycle (set by the multiplier). Row period = W+2 (ISSUE ... done_row, COMPARE).
- start sampled at cycle 0 -> begin_mult at cycle 1 -> result_valid at cycle NUM_ROWS*(W+2)+1.
- The next begin_mult comes 2 cycles after done_row, so the multiplier is back in idle when it samples begin_mult.
- Reset mid-run: immediate return to reset values. The multiplier shares n_rst and is reset too.

## Test plan
- Reset: hold n_rst=0, toggle start -> all outputs 0, begin_mult never pulses.
- Stub multiplier W=5, results row k = 100*k-300 -> 10 begin_mult pulses with row_select 0..9, result_valid at cycle 71, digit=9, max_value=600, ovf_seen=0.
- Ties and negatives: all rows -7 except rows 3 and 6 = 42 -> digit=3, max_value=42.
- Overflow: row 4 returns row_result=32'h8000_0001 with overflow=1, others <=1000 -> row 4 saturates to 32'h7FFF_FFFF, digit=4, ovf_seen=1. Row 2 returns 32'h0000_0010 with overflow=1 -> saturates to 32'h8000_0000, does not win.
- Timeout, TIMEOUT=20: stub never answers row 2 -> timeout_err=1 at 20 cycles into WAIT, busy=0, no result_valid. A later start clears timeout_err and completes normally.
- Real multiplier integration: start with pixel/weight memories loaded from a golden vector -> digit and max_value match the software model. Start pulsed while busy is ignored. n_rst asserted mid-row-5 aborts cleanly and a fresh start then completes.

Source files
------------

// File: rtl/classifier_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module   : classifier_sequencer_if
// Purpose  : Row-engine handshake plus start/result bus of classifier_sequencer.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
interface classifier_sequencer_if;
  logic        start;
  logic [31:0] row_result;
  logic        overflow;
  logic        done_row;
  logic [3:0]  row_select;
  logic        begin_mult;
  logic        busy;
  logic        result_valid;
  logic [3:0]  digit;
  logic [31:0] max_value;
  logic        ovf_seen;
  logic        timeout_err;

  modport master (
    input  start, row_result, overflow, done_row,
    output row_select, begin_mult, busy, result_valid,
           digit, max_value, ovf_seen, timeout_err
  );

  modport slave (
    output start, row_result, overflow, done_row,
    input  row_select, begin_mult, busy, result_valid,
           digit, max_value, ovf_seen, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/classifier_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module   : classifier_sequencer
// Purpose  : Issues one multiplier row per class and tracks the arg-max result.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module classifier_sequencer #(
  parameter int NUM_ROWS = 10,
  parameter int TIMEOUT  = 1023
) (
  input  wire logic              clk,
  input  wire logic              n_rst,
  classifier_sequencer_if.master bus
);

  localparam int          c_WD_W     = (TIMEOUT < 3) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
  localparam logic [3:0]  c_LAST_ROW = 4'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic [3:0]         r_row;
  logic [c_WD_W-1:0]  r_wd;
  logic signed [31:0] r_sample;
  logic signed [31:0] r_max;
  logic [3:0]         r_digit;
  logic               r_ovf;
  logic               r_tmo;
  logic               r_begin;
  logic               r_valid;

  logic signed [31:0] w_sample;
  logic               w_better;

  // An overflowed sum has the wrong sign bit, so the sign tells the wrap direction.
  always_comb begin
    w_sample = $signed(bus.row_result);
    if (bus.overflow) begin
      w_sample = bus.row_result[31] ? 32'sh7FFF_FFFF : 32'sh8000_0000;
    end
  end

  assign w_better = (r_row == 4'd0) || (r_sample > r_max);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_row    <= 4'd0;
      r_wd     <= '0;
      r_sample <= '0;
      r_max    <= '0;
      r_digit  <= 4'd0;
      r_ovf    <= 1'b0;
      r_tmo    <= 1'b0;
      r_begin  <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_begin <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_row <= 4'd0;
          if (bus.start) begin
            r_state <= S_ISSUE;
            r_begin <= 1'b1;
            r_wd    <= '0;
            r_max   <= '0;
            r_digit <= 4'd0;
            r_ovf   <= 1'b0;
            r_tmo   <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // done_row takes priority over an expiring watchdog.
          if (bus.done_row) begin
            r_sample <= w_sample;
            r_ovf    <= r_ovf | bus.overflow;
            r_state  <= S_COMPARE;
          end else if (r_wd == c_WD_LAST) begin
            r_tmo   <= 1'b1;
            r_row   <= 4'd0;
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + c_WD_W'(1);
          end
        end
        S_COMPARE: begin
          if (w_better) begin
            r_max   <= r_sample;
            r_digit <= r_row;
          end
          if (r_row == c_LAST_ROW) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
          end else begin
            r_row   <= r_row + 4'd1;
            r_begin <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_DONE: begin
          r_row   <= 4'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_row   <= 4'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.row_select   = r_row;
  assign bus.begin_mult   = r_begin;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.result_valid = r_valid;
  assign bus.digit        = r_digit;
  assign bus.max_value    = r_max;
  assign bus.ovf_seen     = r_ovf;
  assign bus.timeout_err  = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_classifier_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module   : tb_classifier_sequencer
// Purpose  : Vector table + scoreboard bench with a stub row multiplier (W=5).
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_classifier_sequencer;
  localparam int NR  = 10;
  localparam int TMO = 20;
  localparam int W   = 5;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  classifier_sequencer_if bus();

  classifier_sequencer #(.NUM_ROWS(NR), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [9:0][31:0] vals;
    logic [9:0]       ovf;
    logic [3:0]       exp_digit;
    logic [31:0]      exp_max;
    logic             exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [3:0]  digit;
    logic [31:0] maxv;
    logic        ovf;
  } exp_t;

  vec_t vecs[6];
  exp_t sbq[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [9:0][31:0] cur_vals;
  logic [9:0]       cur_ovf;
  int no_answer_row = -1;
  int bm_cnt = 0, sel_err = 0, rv_cnt = 0, rv_cycle = 0, exp_row = 0;
  int last_bm_cycle = 0, stub_r = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Stub multiplier: answers W cycles after begin_mult with the current vector.
  initial begin
    bus.done_row = 1'b0; bus.row_result = '0; bus.overflow = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.begin_mult === 1'b1) begin
        stub_r = int'(bus.row_select);
        bm_cnt++;
        last_bm_cycle = cyc;
        if (stub_r != exp_row) sel_err++;
        exp_row = stub_r + 1;
        if (stub_r != no_answer_row) begin
          repeat (W) @(posedge clk);
          #1;
          bus.done_row = 1'b1; bus.row_result = cur_vals[stub_r]; bus.overflow = cur_ovf[stub_r];
          @(negedge clk);
          if (n_rst && bus.row_select !== 4'(stub_r)) sel_err++;
          @(posedge clk);
          #1;
          bus.done_row = 1'b0; bus.row_result = '0; bus.overflow = 1'b0;
        end
      end
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (n_rst && bus.result_valid === 1'b1) begin
      rv_cnt++;
      rv_cycle = cyc;
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result_valid: actual=1 required=0");
      end else begin
        mon_e = sbq.pop_front();
        check("digit", 32'(bus.digit), 32'(mon_e.digit));
        check("max_value", bus.max_value, mon_e.maxv);
        check("ovf_seen", 32'(bus.ovf_seen), 32'(mon_e.ovf));
      end
    end
  end

  task automatic run_vec(input int idx, input bit push, input bit poke);
    int t0, rv0, bm0, guard;
    cur_vals = vecs[idx].vals; cur_ovf = vecs[idx].ovf;
    exp_row = 0; sel_err = 0; bm0 = bm_cnt; rv0 = rv_cnt;
    if (push) sbq.push_back({vecs[idx].exp_digit, vecs[idx].exp_max, vecs[idx].exp_ovf});
    @(posedge clk); #1 bus.start = 1'b1; t0 = cyc;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    check("first_begin_mult", 32'(bus.begin_mult), 32'd1);
    check("first_busy", 32'(bus.busy), 32'd1);
    check("first_row_select", 32'(bus.row_select), 32'd0);
    check("timeout_err_cleared", 32'(bus.timeout_err), 32'd0);
    if (poke) begin
      repeat (20) @(posedge clk);
      #1 bus.start = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.start = 1'b0;
    end
    guard = 0;
    while (bus.busy === 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++; failures++;
      $display("FAIL run_bound: actual=busy required=idle");
    end
    if (push) begin
      check("result_valid_count", 32'(rv_cnt - rv0), 32'd1);
      check("latency", 32'(rv_cycle - t0), 32'd71);
      check("begin_mult_count", 32'(bm_cnt - bm0), 32'd10);
      check("row_select_seq_errors", 32'(sel_err), 32'd0);
      check("timeout_err", 32'(bus.timeout_err), 32'd0);
    end
  endtask

  initial begin
    int bm0, rv0, guard;
    for (int k = 0; k < 10; k++) begin
      vecs[0].vals[k] = 32'(100 * k - 300);
      vecs[1].vals[k] = (k == 3 || k == 6) ? 32'd42 : 32'(-7);
      vecs[2].vals[k] = 32'(100 * k);
      vecs[3].vals[k] = 32'd5;
      vecs[4].vals[k] = 32'(-1000 - k);
      vecs[5].vals[k] = 32'(-50);
    end
    for (int i = 0; i < 6; i++) vecs[i].ovf = '0;
    vecs[2].vals[4] = 32'h8000_0001; vecs[2].ovf[4] = 1'b1;
    vecs[2].vals[2] = 32'h0000_0010; vecs[2].ovf[2] = 1'b1;
    vecs[5].vals[9] = 32'h0000_0010; vecs[5].ovf[9] = 1'b1;
    vecs[0].exp_digit = 4'd9; vecs[0].exp_max = 32'd600;        vecs[0].exp_ovf = 1'b0;
    vecs[1].exp_digit = 4'd3; vecs[1].exp_max = 32'd42;         vecs[1].exp_ovf = 1'b0;
    vecs[2].exp_digit = 4'd4; vecs[2].exp_max = 32'h7FFF_FFFF;  vecs[2].exp_ovf = 1'b1;
    vecs[3].exp_digit = 4'd0; vecs[3].exp_max = 32'd5;          vecs[3].exp_ovf = 1'b0;
    vecs[4].exp_digit = 4'd0; vecs[4].exp_max = 32'(-1000);     vecs[4].exp_ovf = 1'b0;
    vecs[5].exp_digit = 4'd0; vecs[5].exp_max = 32'(-50);       vecs[5].exp_ovf = 1'b1;

    // Reset held while start toggles.
    bus.start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1 bus.start = ~bus.start;
    end
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_begin_mult", 32'(bus.begin_mult), 32'd0);
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("rst_row_select", 32'(bus.row_select), 32'd0);
    check("rst_digit", 32'(bus.digit), 32'd0);
    check("rst_max_value", bus.max_value, 32'd0);
    check("rst_ovf_seen", 32'(bus.ovf_seen), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("rst_begin_mult_pulses", 32'(bm_cnt), 32'd0);
    @(posedge clk); #1 bus.start = 1'b0; n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven runs; the first one also pokes start while busy.
    for (int i = 0; i < 6; i++) run_vec(i, 1'b1, i == 0);

    // Watchdog abort: row 2 never answers.
    no_answer_row = 2;
    rv0 = rv_cnt;
    run_vec(0, 1'b0, 1'b0);
    check("timeout_wait_cycles", 32'(cyc - last_bm_cycle), 32'd21);
    check("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    check("timeout_partial_digit", 32'(bus.digit), 32'd1);
    check("timeout_partial_max", bus.max_value, 32'(-200));
    check("timeout_no_result_valid", 32'(rv_cnt - rv0), 32'd0);
    no_answer_row = -1;
    run_vec(1, 1'b1, 1'b0);

    // Reset in the middle of row 5, then a clean rerun.
    cur_vals = vecs[2].vals; cur_ovf = vecs[2].ovf; exp_row = 0;
    bm0 = bm_cnt;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    guard = 0;
    while (!(bus.begin_mult === 1'b1 && bus.row_select == 4'd5) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("reached_row5", 32'(guard < 200), 32'd1);
    check("ovf_before_reset", 32'(bus.ovf_seen), 32'd1);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_row_select", 32'(bus.row_select), 32'd0);
    check("midrst_max_value", bus.max_value, 32'd0);
    check("midrst_ovf_seen", 32'(bus.ovf_seen), 32'd0);
    repeat (10) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (3) @(posedge clk);
    run_vec(2, 1'b1, 1'b0);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
